// File: rtl/dds_pkg.sv
// dds_pkg: shared defaults and FSM state encoding for the DDS tuning-word scheduler.
package dds_pkg;
    localparam int unsigned CLK_FREQ   = 100_000_000;
    localparam int          PHASE_BITS = 32;
    localparam int          FREQ_BITS  = 16;
    localparam int          DIV_BITS   = FREQ_BITS + PHASE_BITS;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_DIVIDE = 2'd2;
    localparam state_t ST_WRITE  = 2'd3;
endpackage

// File: rtl/ftw_seq_divider.sv
// ftw_seq_divider: restoring divider, one quotient bit per cycle MSB first; done_o marks the final iteration.
module ftw_seq_divider
    import dds_pkg::*;
#(
    parameter int W = DIV_BITS
)(
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);
    localparam int CW = W > 1 ? $clog2(W) : 1;

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, ge;
    logic [W:0]    trial;

    assign done_o = run_q && (cnt_q == CW'(W - 1));
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

    // Dividend shifts out of quo_q's top while quotient bits shift in at the bottom.
    always_comb begin
        trial = {rem_q, quo_q[W-1]};
        ge    = trial >= {1'b0, divisor_i};
        rem_d = start_i ? '0 : run_q ? (ge ? trial[W-1:0] - divisor_i : trial[W-1:0]) : rem_q;
        quo_d = start_i ? dividend_i : run_q ? {quo_q[W-2:0], ge} : quo_q;
        cnt_d = start_i ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
        run_d = start_i || (run_q && !done_o);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/dds_tuning_scheduler.sv
// dds_tuning_scheduler: round-robin FTW computation for NUM_CH DDS channels on one shared divider.
// Define DDS_FTW_ROUND_EN for round-to-nearest tuning words instead of truncation.
module dds_tuning_scheduler #(
    parameter int          NUM_CH     = 4,
    parameter int unsigned CLK_FREQ   = dds_pkg::CLK_FREQ,
    parameter int          PHASE_BITS = dds_pkg::PHASE_BITS,
    parameter int          FREQ_BITS  = dds_pkg::FREQ_BITS
)(
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NUM_CH-1:0]              req_valid_i,
    input  logic [NUM_CH*FREQ_BITS-1:0]    req_freq_i,
    output logic [NUM_CH-1:0]              req_ready_o,
    output logic [NUM_CH*PHASE_BITS-1:0]   ftw_o,
    output logic [NUM_CH-1:0]              ftw_update_o,
    output logic                           busy_o
);
    import dds_pkg::*;

    localparam int DW = FREQ_BITS + PHASE_BITS;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    state_t                             state_q, state_d;
    logic [CW-1:0]                      rr_q, rr_d, ch_q, ch_d, gidx;
    logic [FREQ_BITS-1:0]               freq_q, freq_d, gfreq;
    logic [NUM_CH-1:0]                  grant, upd_q, upd_d;
    logic [NUM_CH-1:0][PHASE_BITS-1:0]  ftw_q, ftw_d;
    logic                               found, fire, div_done;
    logic [DW-1:0]                      quo, rem;
    logic [PHASE_BITS-1:0]              result;

    // First requester at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        gidx  = '0;
        gfreq = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (!found && req_valid_i[idx]) begin
                grant[idx] = 1'b1;
                gidx       = CW'(idx);
                gfreq      = req_freq_i[idx*FREQ_BITS +: FREQ_BITS];
                found      = 1'b1;
            end
        end
    end

    assign fire         = found && (state_q == ST_IDLE);
    assign req_ready_o  = (state_q == ST_IDLE && !reset_i) ? grant : '0;
    assign busy_o       = state_q != ST_IDLE;
    assign ftw_o        = ftw_q;
    assign ftw_update_o = upd_q;

    ftw_seq_divider #(.W(DW)) u_div (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (state_q == ST_LOAD),
        .dividend_i ({freq_q, {PHASE_BITS{1'b0}}}),
        .divisor_i  (DW'(CLK_FREQ)),
        .done_o     (div_done),
        .quot_o     (quo),
        .rem_o      (rem)
    );

`ifdef DDS_FTW_ROUND_EN
    logic unused_quo;
    assign unused_quo = ^quo[DW-1:PHASE_BITS];
    assign result     = quo[PHASE_BITS-1:0] + PHASE_BITS'({rem, 1'b0} >= (DW+1)'(CLK_FREQ));
`else
    logic unused_quo;
    assign unused_quo = ^{quo[DW-1:PHASE_BITS], rem};
    assign result     = quo[PHASE_BITS-1:0];
`endif

    always_comb begin
        state_d = (state_q == ST_IDLE)   ? (fire ? ST_LOAD : ST_IDLE) :
                  (state_q == ST_LOAD)   ? ST_DIVIDE :
                  (state_q == ST_DIVIDE) ? (div_done ? ST_WRITE : ST_DIVIDE) : ST_IDLE;
        rr_d    = fire ? ((gidx == CW'(NUM_CH - 1)) ? '0 : gidx + 1'b1) : rr_q;
        ch_d    = fire ? gidx : ch_q;
        freq_d  = fire ? gfreq : freq_q;
        ftw_d   = ftw_q;
        upd_d   = '0;
        if (state_q == ST_WRITE) begin
            ftw_d[ch_q] = result;
            upd_d[ch_q] = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            ch_q    <= '0;
            freq_q  <= '0;
            ftw_q   <= '0;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            freq_q  <= freq_d;
            ftw_q   <= ftw_d;
            upd_q   <= upd_d;
        end
    end
endmodule

// File: doc/dds_tuning_scheduler.md
Name: dds_tuning_scheduler

Overview:
- Converts per-channel frequency requests (Hz) into DDS frequency tuning words (FTW = freq·2^PHASE_BITS / CLK_FREQ) for NUM_CH phase accumulators.
- All channels share one iterative restoring divider; requesters are served round-robin.
- Each channel's FTW register drives that channel's phase accumulator increment input.
- Replaces a per-accumulator divider IP instance with one small shared sequential datapath.

Parameters:
- NUM_CH, 4: number of requesting channels / FTW outputs.
- CLK_FREQ, 100_000_000: system clock in Hz, used as divisor. Must exceed 2^FREQ_BITS−1.
- PHASE_BITS, 32: FTW width = phase accumulator width.
- FREQ_BITS, 16: requested frequency width (Hz, unsigned).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel update request.
- req_freq  in  NUM_CH*FREQ_BITS  per-channel frequency in Hz; channel i at bits [i*FREQ_BITS +: FREQ_BITS].
- req_ready  out  NUM_CH  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- ftw  out  NUM_CH*PHASE_BITS  per-channel tuning word; channel i at [i*PHASE_BITS +: PHASE_BITS].
- ftw_update  out  NUM_CH  one-cycle pulse: ftw[i] has just changed.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async): state=IDLE, rr pointer=0, all ftw=0, ftw_update=0, req_ready=0, busy=0; divider cleared; any in-flight request is dropped.
- FSM states:
  - IDLE: req_ready is combinational. Exactly one bit is set: the first channel with req_valid=1, searching from the rr pointer upward with wrap. All zero if no request. On handshake → LOAD; latch channel index and req_freq; rr pointer ← granted+1 mod NUM_CH.
  - LOAD: one cycle. Dividend = freq << PHASE_BITS (FREQ_BITS+PHASE_BITS wide), divisor = CLK_FREQ, remainder=0; start divider → DIVIDE.
  - DIVIDE: restoring division, one quotient bit per cycle, MSB first, exactly FREQ_BITS+PHASE_BITS cycles (48 default) → WRITE.
  - WRITE: ftw[ch] ← low PHASE_BITS of quotient (floor); ftw_update[ch]=1 next cycle for exactly one cycle → IDLE.
- Latency: accept edge E0; ftw[ch] and ftw_update[ch] visible after edge E0+FREQ_BITS+PHASE_BITS+2 (50 default).
- Throughput: one request per FREQ_BITS+PHASE_BITS+3 cycles (51).
- req_ready is 0 outside IDLE. Requesters may hold or drop req_valid freely before the handshake.
- req_freq is sampled only at the handshake edge; later changes are ignored.
- freq=0 → ftw=0 (valid update, pulse still issued).
- Other channels' ftw hold their values throughout.
- A channel re-requesting while being processed is served on a later IDLE per round-robin order.

Optional Feature:
- Macro DDS_FTW_ROUND_EN.
- Defined: in WRITE, if 2·remainder ≥ CLK_FREQ, the quotient is incremented (round-to-nearest, wraps mod 2^PHASE_BITS). Latency unchanged.
- Undefined: truncation (floor), remainder compare logic absent.

Decomposition:
- Package dds_pkg: CLK_FREQ, PHASE_BITS, FREQ_BITS defaults, DIV_BITS=FREQ_BITS+PHASE_BITS, FSM state enum (IDLE, LOAD, DIVIDE, WRITE).
- Sub-module ftw_seq_divider: start/done restoring divider with quotient and remainder outputs. Contains the iteration counter and the remainder/quotient shift registers.
- Top level holds the arbiter, FSM and FTW register bank.

Test Plan:
- ch0 req 1000 Hz → after 50 cycles ftw[0]=42949 (42950 with DDS_FTW_ROUND_EN), ftw_update=0001 for one cycle, other ftw=0.
- ch2 req 65535 → ftw[2]=2814706 (2814707 rounded); ch1 req 1 → ftw[1]=42 (43 rounded); ch3 req 0 → ftw[3]=0 with pulse.
- All four req_valid held high from reset release → grants in order 0,1,2,3 spaced 51 cycles. Then, with rr=0 and only ch3,ch1 requesting, ch1 is served before ch3.
- Change req_freq[0] from 1000 to 2000 one cycle after handshake → result still 42949.
- Assert reset at cycle 20 of DIVIDE → all ftw=0, busy=0, no ftw_update pulse. Request is re-served only if re-presented after reset.
- Drop req_valid before any grant while busy → no handshake recorded, no update.
